dbus_ahb_arbiter: RTL and testbench

Two-master AHB-Lite arbiter for the core data bus. It shares the single data-side slave port between the core LSU (master 0) and a DMA/debug master (master 1). Master 0 has fixed priority, and a starvation counter guarantees master 1 progress. It sits between the LSU's d_h* outputs and the data-bus interconnect/ITCM decoder.

---
 rtl/dbus_ahb_arbiter_pkg.sv | 29 ++
 rtl/dbus_ahb_arbiter.sv | 122 ++++++++++++
 tb/tb_dbus_ahb_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dbus_ahb_arbiter_pkg.sv
// Shared AHB-Lite encodings and command-bus field layout for the data-bus arbiter.
// Command word layout: {hprot[3:0], hburst[2:0], hsize[2:0], hwrite, htrans[1:0], haddr}.
package dbus_ahb_arbiter_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Field offsets are relative to the top of haddr; add AW to get absolute bit positions.
  localparam int CMD_TRANS_LSB = 0;
  localparam int CMD_BURST_LSB = 6;
  localparam int CMD_CTRL_W    = 13;

  function automatic logic is_switch_point(input logic [1:0] trans, input logic [2:0] burst);
    return (trans == HTRANS_IDLE) ||
           ((trans == HTRANS_NONSEQ) && (burst == HBURST_SINGLE));
  endfunction

endpackage

// File: rtl/dbus_ahb_arbiter.sv
// Two-master AHB-Lite arbiter: LSU (m0) has fixed priority, a starvation counter
// forces the DMA/debug master (m1) ahead after STARVE_MAX lost arbitration points.
module dbus_ahb_arbiter
  import dbus_ahb_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AW+CMD_CTRL_W-1:0] m0_cmd,
  input  logic [DW-1:0]            m0_hwdata,
  output logic [DW-1:0]            m0_hrdata,
  output logic                     m0_hready,
  input  logic [AW+CMD_CTRL_W-1:0] m1_cmd,
  input  logic [DW-1:0]            m1_hwdata,
  output logic [DW-1:0]            m1_hrdata,
  output logic                     m1_hready,
  output logic [AW+CMD_CTRL_W-1:0] s_cmd,
  output logic [DW-1:0]            s_hwdata,
  input  logic [DW-1:0]            s_hrdata,
  input  logic                     s_hready,
  output logic                     grant_m1
);

  localparam int         CMD_W      = AW + CMD_CTRL_W;
  localparam int         TRANS_BIT  = AW + CMD_TRANS_LSB;
  localparam int         BURST_BIT  = AW + CMD_BURST_LSB;
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  owner_e           r_aowner;
  owner_e           r_downer;
  owner_e           w_aowner_nxt;
  logic             r_dvalid;
  logic [7:0]       r_starve_cnt;
  logic [7:0]       w_starve_nxt;
  logic             w_req0;
  logic             w_req1;
  logic [CMD_W-1:0] w_own_cmd;
  logic [1:0]       w_own_trans;
  logic [2:0]       w_own_burst;
  logic             w_switch;

  assign w_req0      = m0_cmd[TRANS_BIT+1];
  assign w_req1      = m1_cmd[TRANS_BIT+1];
  assign w_own_cmd   = (r_aowner == OWN_M1) ? m1_cmd : m0_cmd;
  assign w_own_trans = w_own_cmd[TRANS_BIT +: 2];
  assign w_own_burst = w_own_cmd[BURST_BIT +: 3];
  // An owner mid-burst (SEQ, BUSY or a burst NONSEQ) is never preempted.
  assign w_switch    = s_hready && is_switch_point(w_own_trans, w_own_burst);

  assign s_cmd     = w_own_cmd;
  assign s_hwdata  = (r_downer == OWN_M1) ? m1_hwdata : m0_hwdata;
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;
  assign grant_m1  = (r_aowner == OWN_M1);

  always_comb begin
    w_aowner_nxt = r_aowner;
    w_starve_nxt = r_starve_cnt;
    if (w_switch) begin
      if (w_req0 && (r_starve_cnt < STARVE_LIM)) begin
        w_aowner_nxt = OWN_M0;
      end else if (w_req1) begin
        w_aowner_nxt = OWN_M1;
      end else begin
        w_aowner_nxt = OWN_M0;
      end
      if (w_aowner_nxt == OWN_M1) begin
        w_starve_nxt = 8'd0;
      end else if (w_req1 && (r_starve_cnt != 8'hFF)) begin
        w_starve_nxt = r_starve_cnt + 8'd1;
      end else begin
        w_starve_nxt = r_starve_cnt;
      end
    end else begin
      w_aowner_nxt = r_aowner;
      w_starve_nxt = r_starve_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aowner     <= OWN_M0;
      r_downer     <= OWN_M0;
      r_dvalid     <= 1'b0;
      r_starve_cnt <= 8'd0;
    end else if (s_hready) begin
      r_aowner     <= w_aowner_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_dvalid     <= w_own_trans[1];
      r_downer     <= r_aowner;
    end else begin
      r_aowner     <= r_aowner;
      r_downer     <= r_downer;
      r_dvalid     <= r_dvalid;
      r_starve_cnt <= r_starve_cnt;
    end
  end

  // A master sees the slave's ready only while it owns a phase; otherwise it is stalled if requesting.
  always_comb begin
    m0_hready = 1'b1;
    m1_hready = 1'b1;
    if ((r_aowner == OWN_M0) || (r_dvalid && (r_downer == OWN_M0))) begin
      m0_hready = s_hready;
    end else if (w_req0) begin
      m0_hready = 1'b0;
    end else begin
      m0_hready = 1'b1;
    end
    if ((r_aowner == OWN_M1) || (r_dvalid && (r_downer == OWN_M1))) begin
      m1_hready = s_hready;
    end else if (w_req1) begin
      m1_hready = 1'b0;
    end else begin
      m1_hready = 1'b1;
    end
  end

endmodule

// File: tb/tb_dbus_ahb_arbiter.sv
// Directed, table-driven bench for dbus_ahb_arbiter with STARVE_MAX=3; each row is one
// clock of stimulus plus hand-computed grant/hready/data-owner expectations.
module tb_dbus_ahb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = AW + 13;

  localparam logic [1:0] TI = 2'b00;
  localparam logic [1:0] TB = 2'b01;
  localparam logic [1:0] TN = 2'b10;
  localparam logic [1:0] TS = 2'b11;
  localparam logic [2:0] BS = 3'b000;
  localparam logic [2:0] B4 = 3'b011;

  localparam logic [DW-1:0] M0_WDATA = 32'h0BAD_F00D;
  localparam logic [DW-1:0] M1_WDATA = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] m0_cmd;
  logic [DW-1:0] m0_hwdata;
  logic [DW-1:0] m0_hrdata;
  logic          m0_hready;
  logic [CW-1:0] m1_cmd;
  logic [DW-1:0] m1_hwdata;
  logic [DW-1:0] m1_hrdata;
  logic          m1_hready;
  logic [CW-1:0] s_cmd;
  logic [DW-1:0] s_hwdata;
  logic [DW-1:0] s_hrdata;
  logic          s_hready;
  logic          grant_m1;

  always #5 clk = ~clk;

  dbus_ahb_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_cmd    (m0_cmd),
    .m0_hwdata (m0_hwdata),
    .m0_hrdata (m0_hrdata),
    .m0_hready (m0_hready),
    .m1_cmd    (m1_cmd),
    .m1_hwdata (m1_hwdata),
    .m1_hrdata (m1_hrdata),
    .m1_hready (m1_hready),
    .s_cmd     (s_cmd),
    .s_hwdata  (s_hwdata),
    .s_hrdata  (s_hrdata),
    .s_hready  (s_hready),
    .grant_m1  (grant_m1)
  );

  typedef struct {
    logic [1:0] t0;
    logic [2:0] b0;
    logic [1:0] t1;
    logic [2:0] b1;
    logic       rdy;
    logic       g;
    logic       h0;
    logic       h1;
    logic       ds;
  } vec_t;

  vec_t vecs [64];
  int   nvec  = 0;
  int   total = 0;
  int   bad   = 0;

  function automatic logic [CW-1:0] mk_cmd(input logic [1:0] t, input logic [2:0] b,
                                           input logic w, input logic [AW-1:0] a);
    return {4'b0011, b, 3'b010, w, t, a};
  endfunction

  task automatic add(input logic [1:0] t0, input logic [2:0] b0, input logic [1:0] t1,
                     input logic [2:0] b1, input logic rdy, input logic g, input logic h0,
                     input logic h1, input logic ds);
    vecs[nvec] = '{t0: t0, b0: b0, t1: t1, b1: b1, rdy: rdy, g: g, h0: h0, h1: h1, ds: ds};
    nvec++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] t0, input logic [2:0] b0, input logic [1:0] t1,
                       input logic [2:0] b1, input logic rdy);
    m0_cmd   = mk_cmd(t0, b0, 1'b0, 32'h0000_1000);
    m1_cmd   = mk_cmd(t1, b1, 1'b1, 32'h2000_0000);
    s_hready = rdy;
  endtask

  initial begin
    logic [DW-1:0] rdata;
    m0_hwdata = M0_WDATA;
    m1_hwdata = M1_WDATA;
    s_hrdata  = 32'h0;

    // m0 read 0x1000 with one wait state
    add(TN, BS, TI, BS, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add(TI, BS, TI, BS, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add(TI, BS, TI, BS, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    // m1 single write: held, granted, accepted, data phase
    add(TI, BS, TN, BS, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(TI, BS, TN, BS, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    add(TI, BS, TI, BS, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    add(TI, BS, TI, BS, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    // both request singles every cycle: m0 wins 3 points, then m1, repeating
    add(TN, BS, TN, BS, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(TN, BS, TN, BS, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(TN, BS, TN, BS, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(TN, BS, TN, BS, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(TN, BS, TN, BS, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    add(TN, BS, TN, BS, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    add(TN, BS, TN, BS, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(TN, BS, TN, BS, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(TN, BS, TN, BS, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    add(TI, BS, TI, BS, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    // m1 INCR4 burst with a BUSY beat; m0 requests from beat 2 and waits for m1's IDLE
    add(TI, BS, TN, B4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(TI, BS, TN, B4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    add(TN, BS, TS, B4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    add(TN, BS, TB, B4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    add(TN, BS, TS, B4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    add(TN, BS, TS, B4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    add(TN, BS, TI, BS, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    add(TN, BS, TI, BS, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    // five wait states in m0 data phase with m1 pending: everything frozen
    for (int k = 0; k < 5; k++) add(TI, BS, TN, BS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(TI, BS, TN, BS, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(TI, BS, TN, BS, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    add(TI, BS, TI, BS, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    // reset held with both masters requesting
    rst = 1'b1;
    drive(TN, BS, TN, BS, 1'b1);
    #2;
    chk("rst grant", 64'(grant_m1), 64'(1'b0));
    chk("rst s_cmd", 64'(s_cmd), 64'(mk_cmd(TN, BS, 1'b0, 32'h0000_1000)));
    chk("rst m0_hready", 64'(m0_hready), 64'(1'b1));
    chk("rst m1_hready", 64'(m1_hready), 64'(1'b0));
    s_hready = 1'b0;
    #1;
    chk("rst m0_hready wait", 64'(m0_hready), 64'(1'b0));
    drive(TN, BS, TI, BS, 1'b1);
    #1;
    chk("rst m1_hready idle", 64'(m1_hready), 64'(1'b1));
    drive(TI, BS, TI, BS, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].t0, vecs[i].b0, vecs[i].t1, vecs[i].b1, vecs[i].rdy);
      rdata    = 32'hC0DE_0000 + 32'(i);
      s_hrdata = rdata;
      #2;
      chk($sformatf("row%0d grant", i), 64'(grant_m1), 64'(vecs[i].g));
      chk($sformatf("row%0d m0_hready", i), 64'(m0_hready), 64'(vecs[i].h0));
      chk($sformatf("row%0d m1_hready", i), 64'(m1_hready), 64'(vecs[i].h1));
      chk($sformatf("row%0d s_cmd", i), 64'(s_cmd),
          64'(vecs[i].g ? mk_cmd(vecs[i].t1, vecs[i].b1, 1'b1, 32'h2000_0000)
                        : mk_cmd(vecs[i].t0, vecs[i].b0, 1'b0, 32'h0000_1000)));
      chk($sformatf("row%0d s_hwdata", i), 64'(s_hwdata),
          64'(vecs[i].ds ? M1_WDATA : M0_WDATA));
      chk($sformatf("row%0d m0_hrdata", i), 64'(m0_hrdata), 64'(rdata));
      chk($sformatf("row%0d m1_hrdata", i), 64'(m1_hrdata), 64'(rdata));
      @(posedge clk);
      #1;
    end

    // reset in the middle of an m1 ownership drops it without a clock edge
    drive(TI, BS, TN, BS, 1'b1);
    @(posedge clk);
    #1;
    chk("midrst grant before", 64'(grant_m1), 64'(1'b1));
    rst = 1'b1;
    #1;
    chk("midrst grant", 64'(grant_m1), 64'(1'b0));
    chk("midrst s_cmd", 64'(s_cmd), 64'(mk_cmd(TI, BS, 1'b0, 32'h0000_1000)));
    chk("midrst m1_hready", 64'(m1_hready), 64'(1'b0));
    chk("midrst s_hwdata", 64'(s_hwdata), 64'(M0_WDATA));
    drive(TI, BS, TI, BS, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post rst grant", 64'(grant_m1), 64'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
